// File: rtl/set_job_scheduler_if.sv
// Signal bundle between set_job_scheduler and its two requesters, the shared
// SET engine and the response consumer.
interface set_job_scheduler_if;
   logic        req_a;
   logic [23:0] central_a;
   logic [11:0] radius_a;
   logic [1:0]  mode_a;
   logic        ack_a;
   logic        req_b;
   logic [23:0] central_b;
   logic [11:0] radius_b;
   logic [1:0]  mode_b;
   logic        ack_b;
   logic        set_en;
   logic [23:0] set_central;
   logic [11:0] set_radius;
   logic [1:0]  set_mode;
   logic        set_busy;
   logic        set_valid;
   logic [7:0]  set_candidate;
   logic        resp_valid;
   logic        resp_ready;
   logic        resp_id;
   logic [7:0]  resp_candidate;
   logic        resp_err;
   logic        sched_busy;

   modport slave (
      input  req_a, central_a, radius_a, mode_a,
             req_b, central_b, radius_b, mode_b,
             set_busy, set_valid, set_candidate, resp_ready,
      output ack_a, ack_b, set_en, set_central, set_radius, set_mode,
             resp_valid, resp_id, resp_candidate, resp_err, sched_busy
   );

   modport master (
      output req_a, central_a, radius_a, mode_a,
             req_b, central_b, radius_b, mode_b,
             set_busy, set_valid, set_candidate, resp_ready,
      input  ack_a, ack_b, set_en, set_central, set_radius, set_mode,
             resp_valid, resp_id, resp_candidate, resp_err, sched_busy
   );
endinterface

// File: rtl/set_job_scheduler.sv
// Round-robin scheduler sharing one SET engine between requesters A and B,
// with a WAIT watchdog and a tagged ready/valid response channel.
module set_job_scheduler #(
   parameter int unsigned TIMEOUT = 2048
) (
   input logic                clk,
   input logic                rst,
   set_job_scheduler_if.slave bus
);
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   localparam logic [11:0] CNT_LAST = 12'(TIMEOUT - 32'd1);

   state_e      state_q, state_d;
   logic        rr_ptr_q, rr_ptr_d;
   logic        id_q, id_d;
   logic [11:0] cnt_q, cnt_d;
   logic [23:0] central_q, central_d;
   logic [11:0] radius_q, radius_d;
   logic [1:0]  mode_q, mode_d;
   logic [7:0]  cand_q, cand_d;
   logic        err_q, err_d;
   logic        ack_a_q, ack_a_d;
   logic        ack_b_q, ack_b_d;
   logic        set_en_q, set_en_d;
   logic        resp_valid_q, resp_valid_d;
   logic        busy_q, busy_d;
   logic        pick_b_s;

   // Next-state and next-output logic; outputs are derived so that they can be registered.
   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      id_d      = id_q;
      cnt_d     = cnt_q;
      central_d = central_q;
      radius_d  = radius_q;
      mode_d    = mode_q;
      cand_d    = cand_q;
      err_d     = err_q;
      pick_b_s  = bus.req_b & (~bus.req_a | rr_ptr_q);
      case (state_q)
         ST_IDLE: begin
            if (!bus.set_busy && (bus.req_a || bus.req_b)) begin
               id_d      = pick_b_s;
               central_d = pick_b_s ? bus.central_b : bus.central_a;
               radius_d  = pick_b_s ? bus.radius_b  : bus.radius_a;
               mode_d    = pick_b_s ? bus.mode_b    : bus.mode_a;
               state_d   = ST_ISSUE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            cnt_d   = 12'd0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // A result arriving on the expiry cycle still counts as a success.
            if (bus.set_valid) begin
               cand_d  = bus.set_candidate;
               err_d   = 1'b0;
               state_d = ST_RESP;
            end else if (cnt_q == CNT_LAST) begin
               cand_d  = 8'd0;
               err_d   = 1'b1;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q + 12'd1;
            end
         end
         ST_RESP: begin
            if (resp_valid_q && bus.resp_ready) begin
               rr_ptr_d = ~id_q;
               state_d  = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      set_en_d     = (state_q == ST_ISSUE);
      ack_a_d      = set_en_d & ~id_q;
      ack_b_d      = set_en_d & id_q;
      resp_valid_d = (state_d == ST_RESP);
      busy_d       = (state_d != ST_IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         rr_ptr_q     <= 1'b0;
         id_q         <= 1'b0;
         cnt_q        <= 12'd0;
         central_q    <= 24'd0;
         radius_q     <= 12'd0;
         mode_q       <= 2'd0;
         cand_q       <= 8'd0;
         err_q        <= 1'b0;
         ack_a_q      <= 1'b0;
         ack_b_q      <= 1'b0;
         set_en_q     <= 1'b0;
         resp_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         id_q         <= id_d;
         cnt_q        <= cnt_d;
         central_q    <= central_d;
         radius_q     <= radius_d;
         mode_q       <= mode_d;
         cand_q       <= cand_d;
         err_q        <= err_d;
         ack_a_q      <= ack_a_d;
         ack_b_q      <= ack_b_d;
         set_en_q     <= set_en_d;
         resp_valid_q <= resp_valid_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.ack_a          = ack_a_q;
   assign bus.ack_b          = ack_b_q;
   assign bus.set_en         = set_en_q;
   assign bus.set_central    = central_q;
   assign bus.set_radius     = radius_q;
   assign bus.set_mode       = mode_q;
   assign bus.resp_valid     = resp_valid_q;
   assign bus.resp_id        = id_q;
   assign bus.resp_candidate = cand_q;
   assign bus.resp_err       = err_q;
   assign bus.sched_busy     = busy_q;
endmodule

// File: tb/tb_set_job_scheduler.sv
// Self-checking bench for set_job_scheduler: directed scenarios plus a
// randomized run against a job-level arbitration/result model.
module tb_set_job_scheduler;
   localparam int TO = 128;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   set_job_scheduler_if bus ();
   set_job_scheduler #(.TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

   int total = 0;
   int bad   = 0;

   // Engine model controls (written by the tests only).
   int         eng_lat  = 1;
   logic [7:0] eng_cand = 8'h00;
   bit         eng_hang = 1'b0;
   int         kick_req = 0;
   int         clr_req  = 0;
   // Written by the engine model only.
   int         set_en_cnt = 0;

   // Behavioural engine: result L cycles after set_en, busy until then.
   initial begin : engine
      int remain;
      int kick_seen;
      int clr_seen;
      logic [7:0] hold;
      remain = 0; kick_seen = 0; clr_seen = 0; hold = 8'h00;
      bus.set_busy = 1'b0; bus.set_valid = 1'b0; bus.set_candidate = 8'h00;
      forever begin
         @(negedge clk);
         bus.set_valid = 1'b0;
         if (clr_req != clr_seen) begin
            clr_seen = clr_req; kick_seen = kick_req;
            bus.set_busy = 1'b0; remain = 0;
         end else if (bus.set_en) begin
            bus.set_busy = 1'b1; remain = eng_lat; hold = eng_cand;
            set_en_cnt++;
         end else if (bus.set_busy) begin
            if (!eng_hang) remain = remain - 1;
            if (kick_req != kick_seen || (!eng_hang && remain <= 0)) begin
               kick_seen = kick_req;
               bus.set_valid = 1'b1; bus.set_candidate = hold; bus.set_busy = 1'b0;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; clr_req++;
      bus.req_a = 1'b0; bus.req_b = 1'b0; bus.resp_ready = 1'b0;
      eng_hang = 1'b0;
      step(); step();
      rst = 1'b0;
   endtask

   task automatic wait_ack(input int limit, output bit got_a, output bit got_b, output int cyc);
      cyc = 0;
      while (!(bus.ack_a || bus.ack_b) && cyc < limit) begin
         step(); cyc++;
      end
      got_a = bus.ack_a; got_b = bus.ack_b;
   endtask

   task automatic finish_job(input int limit, output bit ok, output logic id,
                             output logic [7:0] cand, output logic err, output int n);
      n = 0;
      bus.resp_ready = 1'b1;
      while (!bus.resp_valid && n < limit) begin
         step(); n++;
      end
      ok = bus.resp_valid; id = bus.resp_id; cand = bus.resp_candidate; err = bus.resp_err;
      step();
      bus.resp_ready = 1'b0;
   endtask

   function automatic logic [52:0] all_outs();
      return {bus.ack_a, bus.ack_b, bus.set_en, bus.resp_valid, bus.resp_err, bus.sched_busy,
              bus.resp_id, bus.set_central, bus.set_radius, bus.set_mode, bus.resp_candidate};
   endfunction

   task automatic test_reset();
      do_reset();
      total++;
      if (all_outs() !== 53'd0) begin
         bad++; $display("FAIL reset_outs: got %h want 0", all_outs());
      end
      step();
      total++;
      if (bus.sched_busy !== 1'b0) begin
         bad++; $display("FAIL reset_idle: sched_busy got %b want 0", bus.sched_busy);
      end
   endtask

   task automatic test_single();
      bit ga, gb, ok; int cyc, n; logic id; logic [7:0] cand; logic err;
      bus.central_a = 24'h345678; bus.radius_a = 12'h333; bus.mode_a = 2'd0;
      eng_lat = 100; eng_cand = 8'h1C;
      bus.req_a = 1'b1;
      wait_ack(10, ga, gb, cyc);
      total++;
      if ({ga, gb, bus.set_en, cyc} !== {1'b1, 1'b0, 1'b1, 32'd2}) begin
         bad++; $display("FAIL single_ack: ack_a=%b ack_b=%b set_en=%b cyc=%0d want 1 0 1 2", ga, gb, bus.set_en, cyc);
      end
      total++;
      if ({bus.set_central, bus.set_radius, bus.set_mode} !== {24'h345678, 12'h333, 2'd0}) begin
         bad++; $display("FAIL single_payload: got %h %h %h", bus.set_central, bus.set_radius, bus.set_mode);
      end
      bus.req_a = 1'b0;
      step();
      total++;
      if ({bus.ack_a, bus.set_en, bus.sched_busy} !== 3'b001) begin
         bad++; $display("FAIL single_pulse: ack_a=%b set_en=%b busy=%b want 0 0 1", bus.ack_a, bus.set_en, bus.sched_busy);
      end
      finish_job(400, ok, id, cand, err, n);
      total++;
      if ({ok, id, cand, err, n} !== {1'b1, 1'b0, 8'h1C, 1'b0, 32'd100}) begin
         bad++; $display("FAIL single_resp: ok=%b id=%b cand=%h err=%b n=%0d want 1 0 1c 0 100", ok, id, cand, err, n);
      end
      total++;
      if ({bus.resp_valid, bus.sched_busy} !== 2'b00) begin
         bad++; $display("FAIL single_idle: resp_valid=%b busy=%b want 0 0", bus.resp_valid, bus.sched_busy);
      end
   endtask

   task automatic test_simultaneous();
      bit ga, gb, ok; int cyc, n; logic id; logic [7:0] cand; logic err;
      do_reset();
      bus.central_a = 24'hA0A0A0; bus.radius_a = 12'h0A1; bus.mode_a = 2'd1;
      bus.central_b = 24'hB0B0B0; bus.radius_b = 12'h0B2; bus.mode_b = 2'd2;
      eng_lat = 20; eng_cand = 8'd5;
      bus.req_a = 1'b1; bus.req_b = 1'b1;
      wait_ack(10, ga, gb, cyc);
      total++;
      if ({ga, gb} !== 2'b10) begin
         bad++; $display("FAIL sim_first_a: ack_a=%b ack_b=%b want 1 0", ga, gb);
      end
      bus.req_a = 1'b0;
      step();
      eng_cand = 8'd9;
      finish_job(200, ok, id, cand, err, n);
      total++;
      if ({ok, id, cand, err} !== {1'b1, 1'b0, 8'd5, 1'b0}) begin
         bad++; $display("FAIL sim_resp_a: ok=%b id=%b cand=%h err=%b want 1 0 05 0", ok, id, cand, err);
      end
      wait_ack(10, ga, gb, cyc);
      total++;
      if ({ga, gb, bus.set_central, bus.set_mode} !== {2'b01, 24'hB0B0B0, 2'd2}) begin
         bad++; $display("FAIL sim_then_b: ack=%b%b central=%h mode=%0d", ga, gb, bus.set_central, bus.set_mode);
      end
      bus.req_b = 1'b0;
      finish_job(200, ok, id, cand, err, n);
      total++;
      if ({ok, id, cand, err} !== {1'b1, 1'b1, 8'd9, 1'b0}) begin
         bad++; $display("FAIL sim_resp_b: ok=%b id=%b cand=%h err=%b want 1 1 09 0", ok, id, cand, err);
      end
      eng_cand = 8'h0B;
      bus.req_a = 1'b1; bus.req_b = 1'b1;
      wait_ack(10, ga, gb, cyc);
      total++;
      if ({ga, gb} !== 2'b10) begin
         bad++; $display("FAIL sim_rr_a: ack_a=%b ack_b=%b want 1 0", ga, gb);
      end
      bus.req_a = 1'b0;
      step();
      eng_cand = 8'h0C;
      finish_job(200, ok, id, cand, err, n);
      wait_ack(10, ga, gb, cyc);
      bus.req_b = 1'b0;
      finish_job(200, ok, id, cand, err, n);
      total++;
      if ({gb, ok, id, cand} !== {1'b1, 1'b1, 1'b1, 8'h0C}) begin
         bad++; $display("FAIL sim_rr_b: ack_b=%b ok=%b id=%b cand=%h want 1 1 1 0c", gb, ok, id, cand);
      end
   endtask

   task automatic test_back_pressure();
      bit ga, gb, ok; int cyc, n, en_snap; logic id; logic [7:0] cand; logic err;
      logic [9:0] snap;
      bus.central_a = 24'h00F00F; bus.radius_a = 12'h123; bus.mode_a = 2'd3;
      eng_lat = 5; eng_cand = 8'hA5;
      bus.req_a = 1'b1;
      wait_ack(10, ga, gb, cyc);
      bus.req_a = 1'b0;
      cyc = 0;
      while (!bus.resp_valid && cyc < 50) begin
         step(); cyc++;
      end
      snap = {bus.resp_id, bus.resp_err, bus.resp_candidate};
      total++;
      if ({bus.resp_valid, snap} !== {1'b1, 1'b0, 1'b0, 8'hA5}) begin
         bad++; $display("FAIL bp_first: valid=%b fields=%h want 1 0a5", bus.resp_valid, snap);
      end
      eng_cand = 8'h3C;
      bus.central_b = 24'h0BBBBB; bus.radius_b = 12'h456; bus.mode_b = 2'd1;
      bus.req_b = 1'b1;
      en_snap = set_en_cnt;
      for (int i = 0; i < 10; i++) begin
         step();
         total++;
         if ({bus.resp_valid, bus.sched_busy, bus.ack_b, bus.resp_id, bus.resp_err, bus.resp_candidate}
             !== {3'b110, snap}) begin
            bad++; $display("FAIL bp_hold: cycle %0d valid=%b busy=%b ack_b=%b cand=%h", i, bus.resp_valid,
                            bus.sched_busy, bus.ack_b, bus.resp_candidate);
         end
      end
      total++;
      if (set_en_cnt !== en_snap) begin
         bad++; $display("FAIL bp_no_issue: set_en count got %0d want %0d", set_en_cnt, en_snap);
      end
      bus.resp_ready = 1'b1;
      step();
      bus.resp_ready = 1'b0;
      total++;
      if ({bus.resp_valid, bus.sched_busy} !== 2'b00) begin
         bad++; $display("FAIL bp_release: valid=%b busy=%b want 0 0", bus.resp_valid, bus.sched_busy);
      end
      wait_ack(10, ga, gb, cyc);
      bus.req_b = 1'b0;
      finish_job(200, ok, id, cand, err, n);
      total++;
      if ({gb, ok, id, cand, err} !== {1'b1, 1'b1, 1'b1, 8'h3C, 1'b0}) begin
         bad++; $display("FAIL bp_next_b: ack_b=%b ok=%b id=%b cand=%h err=%b", gb, ok, id, cand, err);
      end
   endtask

   task automatic test_timeout();
      bit ga, gb, ok; int cyc, n, acks; logic id; logic [7:0] cand; logic err;
      eng_hang = 1'b1; eng_lat = 1000; eng_cand = 8'h77;
      bus.req_a = 1'b1;
      wait_ack(10, ga, gb, cyc);
      bus.req_a = 1'b0;
      bus.central_b = 24'h123456; bus.radius_b = 12'h789; bus.mode_b = 2'd2;
      bus.req_b = 1'b1;
      finish_job(3 * TO, ok, id, cand, err, n);
      total++;
      if ({ok, id, cand, err, n} !== {1'b1, 1'b0, 8'h00, 1'b1, TO}) begin
         bad++; $display("FAIL to_resp: ok=%b id=%b cand=%h err=%b n=%0d want 1 0 00 1 %0d", ok, id, cand, err, n, TO);
      end
      acks = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus.ack_b) acks++;
         step();
      end
      total++;
      if ({acks, bus.sched_busy} !== {32'd0, 1'b0}) begin
         bad++; $display("FAIL to_hold_b: acks=%0d busy=%b want 0 0", acks, bus.sched_busy);
      end
      eng_cand = 8'h21; eng_lat = 5;
      eng_hang = 1'b0; kick_req++;
      wait_ack(20, ga, gb, cyc);
      total++;
      if ({ga, gb, bus.resp_valid, bus.set_central} !== {2'b01, 1'b0, 24'h123456}) begin
         bad++; $display("FAIL to_then_b: ack=%b%b valid=%b central=%h", ga, gb, bus.resp_valid, bus.set_central);
      end
      bus.req_b = 1'b0;
      finish_job(200, ok, id, cand, err, n);
      total++;
      if ({ok, id, cand, err} !== {1'b1, 1'b1, 8'h21, 1'b0}) begin
         bad++; $display("FAIL to_resp_b: ok=%b id=%b cand=%h err=%b want 1 1 21 0", ok, id, cand, err);
      end
   endtask

   task automatic test_coincident();
      bit ga, gb, ok; int cyc, n; logic id; logic [7:0] cand; logic err;
      int   lat_tab [3] = '{TO - 2, TO - 1, TO};
      logic err_tab [3] = '{1'b0, 1'b0, 1'b1};
      for (int k = 0; k < 3; k++) begin
         eng_lat = lat_tab[k]; eng_cand = 8'h40;
         bus.req_a = 1'b1;
         wait_ack(10, ga, gb, cyc);
         bus.req_a = 1'b0;
         finish_job(3 * TO, ok, id, cand, err, n);
         total++;
         if ({ok, id, err, cand} !== {1'b1, 1'b0, err_tab[k], err_tab[k] ? 8'h00 : 8'h40}) begin
            bad++; $display("FAIL coincide_%0d: ok=%b id=%b err=%b cand=%h want err %b", k, ok, id, err, cand, err_tab[k]);
         end
      end
   endtask

   task automatic test_reset_mid_wait();
      bit ga, gb, ok; int cyc, n, vals; logic id; logic [7:0] cand; logic err;
      eng_lat = 60; eng_cand = 8'h99;
      bus.req_a = 1'b1;
      wait_ack(10, ga, gb, cyc);
      bus.req_a = 1'b0;
      for (int i = 0; i < 10; i++) step();
      rst = 1'b1; clr_req++;
      step();
      total++;
      if (all_outs() !== 53'd0) begin
         bad++; $display("FAIL rst_mid_outs: got %h want 0", all_outs());
      end
      rst = 1'b0;
      vals = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (bus.resp_valid) vals++;
      end
      total++;
      if (vals !== 0) begin
         bad++; $display("FAIL rst_mid_noresp: resp_valid cycles got %0d want 0", vals);
      end
      eng_lat = 7; eng_cand = 8'h5B;
      bus.central_b = 24'hFEDCBA; bus.radius_b = 12'hABC; bus.mode_b = 2'd3;
      bus.req_b = 1'b1;
      wait_ack(10, ga, gb, cyc);
      bus.req_b = 1'b0;
      finish_job(200, ok, id, cand, err, n);
      total++;
      if ({gb, cyc, ok, id, cand, err} !== {1'b1, 32'd2, 1'b1, 1'b1, 8'h5B, 1'b0}) begin
         bad++; $display("FAIL rst_mid_b: ack_b=%b cyc=%0d ok=%b id=%b cand=%h err=%b", gb, cyc, ok, id, cand, err);
      end
   endtask

   // Random traffic; the model only knows "who is waiting", "who was served last"
   // and "did the engine answer within TO cycles of WAIT".
   task automatic test_random();
      logic m_rr;
      do_reset();
      m_rr = 1'b0;
      for (int r = 0; r < 40; r++) begin
         bit ga, gb; int cyc, n, lat; logic exp_id, exp_err; logic [7:0] c, exp_cand;
         logic [37:0] exp_pay;
         if (!bus.req_a && $urandom_range(0, 1) == 1) begin
            bus.central_a = 24'($urandom); bus.radius_a = 12'($urandom); bus.mode_a = 2'($urandom);
            bus.req_a = 1'b1;
         end
         if (!bus.req_b && $urandom_range(0, 1) == 1) begin
            bus.central_b = 24'($urandom); bus.radius_b = 12'($urandom); bus.mode_b = 2'($urandom);
            bus.req_b = 1'b1;
         end
         if (!bus.req_a && !bus.req_b) begin
            bus.central_a = 24'($urandom); bus.radius_a = 12'($urandom); bus.mode_a = 2'($urandom);
            bus.req_a = 1'b1;
         end
         lat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(TO - 2, TO + 2)) : int'($urandom_range(1, 30));
         c = 8'($urandom);
         eng_lat = lat; eng_cand = c;
         exp_id  = (bus.req_a && bus.req_b) ? m_rr : bus.req_b;
         exp_pay = exp_id ? {bus.central_b, bus.radius_b, bus.mode_b} : {bus.central_a, bus.radius_a, bus.mode_a};
         exp_err = (lat >= TO);
         exp_cand = exp_err ? 8'h00 : c;
         wait_ack(3 * TO, ga, gb, cyc);
         total++;
         if ({gb, ga, bus.set_central, bus.set_radius, bus.set_mode} !== {exp_id, ~exp_id, exp_pay}) begin
            bad++; $display("FAIL rand_grant_%0d: ack_b=%b ack_a=%b want id %b", r, gb, ga, exp_id);
         end
         if (exp_id) bus.req_b = 1'b0; else bus.req_a = 1'b0;
         n = 0;
         while (n < 3 * TO) begin
            bus.resp_ready = 1'($urandom_range(0, 1));
            if (bus.resp_valid && bus.resp_ready) break;
            step(); n++;
         end
         total++;
         if ({bus.resp_valid, bus.resp_id, bus.resp_err, bus.resp_candidate} !== {1'b1, exp_id, exp_err, exp_cand}) begin
            bad++; $display("FAIL rand_resp_%0d: valid=%b id=%b err=%b cand=%h want 1 %b %b %h", r, bus.resp_valid,
                            bus.resp_id, bus.resp_err, bus.resp_candidate, exp_id, exp_err, exp_cand);
         end
         step();
         bus.resp_ready = 1'b0;
         m_rr = ~exp_id;
      end
      bus.req_a = 1'b0; bus.req_b = 1'b0;
   endtask

   initial begin
      bus.req_a = 1'b0; bus.central_a = 24'd0; bus.radius_a = 12'd0; bus.mode_a = 2'd0;
      bus.req_b = 1'b0; bus.central_b = 24'd0; bus.radius_b = 12'd0; bus.mode_b = 2'd0;
      bus.resp_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_single();
      test_simultaneous();
      test_back_pressure();
      test_timeout();
      test_coincident();
      test_reset_mid_wait();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
